sga_input_conditioner: RTL and testbench
========================================

Name: sga_input_conditioner

Overview:
Front-end stage directly upstream of the Snake Game Arcade top level. Synchronises and debounces the raw board pushbuttons (4 direction keys, start, pause). Emits clean levels, single-cycle press pulses and an arbitrated, held direction request. Its outputs replace raw switches on the game core's buttons/start/pause inputs.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a clean level changes (1 ms at 50 MHz); legal range 2..2^20
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
buttons_raw  input  4  raw keys, [3]=left [2]=right [1]=up [0]=down, active-high, asynchronous to clock
start_raw  input  1  raw start key, active-high, asynchronous
pause_raw  input  1  raw pause key, active-high, asynchronous
cur_direction  input  2  direction currently applied by game core (same encoding as direction_req)
buttons_clean  output  4  debounced key levels
buttons_pulse  output  4  one-cycle pulse on each clean rising edge
start_pulse  output  1  one-cycle pulse on clean start rising edge
pause_level  output  1  debounced pause level
direction_req  output  2  last accepted direction: 00=left 01=right 10=up 11=down
direction_valid  output  1  one-cycle pulse when direction_req is updated

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset: all synchroniser flops, counters, buttons_clean, buttons_pulse, start_pulse, pause_level, direction_valid = 0; direction_req = 01 (right). Takes effect on the edge it is sampled and overrides every other event, including reset mid-debounce.
- Synchroniser: each of 6 channels passes through 2 flops (sync1, sync2) before debounce.
- Debounce per channel: counter cleared whenever sync2 == clean.
  - While sync2 != clean, counter increments by 1.
  - When counter == DEBOUNCE_CYCLES-1 and sync2 != clean: clean <= sync2 and counter <= 0.
  - Any return of sync2 to the clean value before that point clears the counter (glitch rejected).
  - Counter never exceeds DEBOUNCE_CYCLES-1, so it does not wrap.
- Latency: a clean transition appears exactly 2 + DEBOUNCE_CYCLES clock edges after a raw step that is held steady.
- Pulses: buttons_pulse[i] / start_pulse are registered and high for exactly one cycle, the cycle in which the clean level is first 1. No pulse on a falling edge. A held key gives one pulse only.
- Direction arbitration, evaluated in the cycle buttons_pulse != 0:
  - Candidate is the highest-priority pulsing key: left > right > up > down. Simultaneous pulses resolve by this order; lower keys are dropped, not queued.
  - Candidate accepted, subject to the optional feature, gives direction_req <= candidate code and direction_valid = 1 in the next cycle. Otherwise direction_req holds and direction_valid = 0.
  - A candidate equal to the current direction_req is still accepted and pulses direction_valid; the game core uses it as "played".
- pause_level is a plain debounced level with no toggle logic. The core interprets it.
- No outputs are combinational from raw inputs.

Optional Feature:
SGA_REVERSE_BLOCK_EN:
- Defined: a candidate that is the exact opposite of cur_direction (left<->right, up<->down) is rejected. direction_req holds, direction_valid stays 0, and no lower-priority key is substituted in that cycle.
- Undefined: cur_direction is ignored and every candidate is accepted. The port remains present but unused.

Test Plan:
1. DEBOUNCE_CYCLES=4; assert reset for 2 cycles -> all outputs 0, direction_req=01, with reset deasserted and inputs idle for 20 cycles -> outputs unchanged.
2. DEBOUNCE_CYCLES=4; buttons_raw=0001 held from cycle 0 -> buttons_clean[0] rises at edge 6, buttons_pulse=0001 for exactly 1 cycle, direction_req=11 with direction_valid=1 one cycle later.
3. Glitch: start_raw high for 3 cycles, then low -> start_pulse never asserts and the counter returns to 0. A following 10-cycle press gives exactly one start_pulse.
4. Simultaneous: buttons_raw=1010 (left+up) in the same cycle -> direction_req=00 and a single direction_valid pulse. Releasing and re-pressing up alone -> direction_req=10.
5. With SGA_REVERSE_BLOCK_EN defined and cur_direction=01, press left -> direction_valid stays 0 and direction_req is unchanged. With the macro undefined -> direction_req=00 and direction_valid pulses.
6. Reset mid-debounce: press right, assert reset at counter=2 and keep right held -> after release of reset, clean rises only after a full 2+4 cycles, with no residual count.

Source files
------------

// File: rtl/sga_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sga_input_conditioner
// Purpose  : Pushbutton front end for the Snake Game Arcade core. It does four
//            things for the six raw keys (4 directions, start, pause):
//              - synchronises each key with two flops,
//              - debounces each key with a per-key stability counter,
//              - emits one-cycle press pulses,
//              - arbitrates the direction keys into one held direction request.
// Ports    :
//   clock            in   1  system clock, rising edge
//   reset            in   1  synchronous active-high reset
//   buttons_raw      in   4  raw keys [3]=left [2]=right [1]=up [0]=down
//   start_raw        in   1  raw start key
//   pause_raw        in   1  raw pause key
//   cur_direction    in   2  direction currently applied by the game core
//   buttons_clean    out  4  debounced key levels
//   buttons_pulse    out  4  one-cycle pulse on each clean rising edge
//   start_pulse      out  1  one-cycle pulse on clean start rising edge
//   pause_level      out  1  debounced pause level
//   direction_req    out  2  last accepted direction 00=L 01=R 10=U 11=D
//   direction_valid  out  1  one-cycle pulse when direction_req is updated
// Options  : `define SGA_REVERSE_BLOCK_EN rejects a direction candidate that is
//            the exact opposite of cur_direction. Without it, cur_direction
//            is ignored.
// Revision : 1.0  initial release
// ============================================================================
module sga_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons_raw,
    input  logic       start_raw,
    input  logic       pause_raw,
    input  logic [1:0] cur_direction,
    output logic [3:0] buttons_clean,
    output logic [3:0] buttons_pulse,
    output logic       start_pulse,
    output logic       pause_level,
    output logic [1:0] direction_req,
    output logic       direction_valid
);

    // Channel map: [3:0] direction keys, [4] start, [5] pause.
    localparam int             NUM_CH   = 6;
    localparam int             CH_START = 4;
    localparam int             CH_PAUSE = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] clean_q;
    logic [NUM_CH-1:0] clean_d;

    // Pause needs no pulse, so only the key and start channels get one.
    logic [CH_START:0] pulse_q;
    logic [CH_START:0] pulse_d;

    logic [1:0] dir_req_q;
    logic [1:0] dir_req_d;
    logic       dir_valid_q;
    logic       dir_valid_d;

    logic [1:0] cand_dir;
    logic       cand_present;
    logic       cand_blocked;

    assign raw_vec = {pause_raw, start_raw, buttons_raw};

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for every channel
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_vec;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce. The counter only runs while the synchronised
    // level disagrees with the clean level. Any agreement clears it, which
    // rejects glitches shorter than DEBOUNCE_CYCLES. The counter is cleared
    // on the same edge the clean level flips, so it never passes CNT_MAX.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             match;
        logic             expire;

        assign match  = (sync2_q[i] == clean_q[i]);
        assign expire = !match && (cnt_q == CNT_MAX);

        always_comb begin
            cnt_d = cnt_q;
            if (match || expire) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        assign clean_d[i] = expire ? sync2_q[i] : clean_q[i];

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // A pulse is registered from the next clean value. Because of that, it is
    // high in exactly the first cycle in which the clean level reads 1.
    assign pulse_d = clean_d[CH_START:0] & ~clean_q[CH_START:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            clean_q <= '0;
            pulse_q <= '0;
        end else begin
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    // ------------------------------------------------------------------------
    // Direction arbitration: fixed priority left > right > up > down over the
    // registered pulses. Lower-priority keys in the same cycle are dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        cand_present = |pulse_q[3:0];
        cand_dir     = DIR_DOWN;
        if (pulse_q[3]) begin
            cand_dir = DIR_LEFT;
        end else if (pulse_q[2]) begin
            cand_dir = DIR_RIGHT;
        end else if (pulse_q[1]) begin
            cand_dir = DIR_UP;
        end else begin
            cand_dir = DIR_DOWN;
        end
    end

`ifdef SGA_REVERSE_BLOCK_EN
    // Opposite pairs differ only in bit 0 (L/R = 00/01, U/D = 10/11).
    assign cand_blocked = (cand_dir == (cur_direction ^ 2'b01));
`else
    logic unused_cur_direction;
    assign unused_cur_direction = ^cur_direction;
    assign cand_blocked         = 1'b0;
`endif

    // A blocked candidate is not replaced by a lower-priority key. A candidate
    // equal to the current request is still accepted, so the core sees it as
    // a keypress.
    always_comb begin
        dir_req_d   = dir_req_q;
        dir_valid_d = 1'b0;
        if (cand_present && !cand_blocked) begin
            dir_req_d   = cand_dir;
            dir_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_req_q   <= DIR_RIGHT;
            dir_valid_q <= 1'b0;
        end else begin
            dir_req_q   <= dir_req_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all driven directly from flops
    // ------------------------------------------------------------------------
    assign buttons_clean   = clean_q[3:0];
    assign buttons_pulse   = pulse_q[3:0];
    assign start_pulse     = pulse_q[CH_START];
    assign pause_level     = clean_q[CH_PAUSE];
    assign direction_req   = dir_req_q;
    assign direction_valid = dir_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sga_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sga_input_conditioner
// Purpose  : Directed self-checking bench for sga_input_conditioner.
//            It runs with DEBOUNCE_CYCLES=4 and CNT_W=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_sga_input_conditioner;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] buttons_raw = '0;
    logic       start_raw = 1'b0;
    logic       pause_raw = 1'b0;
    logic [1:0] cur_direction = 2'b00;
    logic [3:0] buttons_clean;
    logic [3:0] buttons_pulse;
    logic       start_pulse;
    logic       pause_level;
    logic [1:0] direction_req;
    logic       direction_valid;

    int n_checks = 0;
    int n_pass   = 0;

    sga_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .buttons_raw     (buttons_raw),
        .start_raw       (start_raw),
        .pause_raw       (pause_raw),
        .cur_direction   (cur_direction),
        .buttons_clean   (buttons_clean),
        .buttons_pulse   (buttons_pulse),
        .start_pulse     (start_pulse),
        .pause_level     (pause_level),
        .direction_req   (direction_req),
        .direction_valid (direction_valid)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({buttons_clean, buttons_pulse, start_pulse, pause_level, direction_valid} !== 11'd0)
            $display("FAIL reset_outputs: got %b want 0",
                     {buttons_clean, buttons_pulse, start_pulse, pause_level, direction_valid});
        else n_pass++;
        n_checks++;
        if (direction_req !== 2'b01) $display("FAIL reset_dir: got %b want 01", direction_req);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if ({buttons_clean, buttons_pulse, start_pulse, pause_level, direction_valid} !== 11'd0)
            $display("FAIL idle_outputs: got %b want 0",
                     {buttons_clean, buttons_pulse, start_pulse, pause_level, direction_valid});
        else n_pass++;
        n_checks++;
        if (direction_req !== 2'b01) $display("FAIL idle_dir: got %b want 01", direction_req);
        else n_pass++;
    endtask

    // Release every direction key and wait until the clean levels are low.
    task automatic release_keys();
        buttons_raw = '0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_single_press();
        int bad;
        cur_direction = 2'b00;
        buttons_raw   = 4'b0001;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (buttons_clean[0] !== (k >= 2 + DEB)) bad++;
            if (buttons_pulse !== ((k == 2 + DEB) ? 4'b0001 : 4'b0000)) bad++;
            if (direction_valid !== (k == 3 + DEB)) bad++;
            if (k == 2 + DEB) begin
                n_checks++;
                if (buttons_clean[0] !== 1'b1) $display("FAIL down_clean_edge6: got %b want 1", buttons_clean[0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL down_timeline: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (direction_req !== 2'b11) $display("FAIL down_dir: got %b want 11", direction_req);
        else n_pass++;
        // Falling edge must give no pulse.
        buttons_raw = '0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (buttons_pulse !== 4'b0000 || direction_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || buttons_clean !== 4'b0000)
            $display("FAIL down_release: got %0d pulse cycles clean=%b want 0/0000", bad, buttons_clean);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int pulses;
        pulses    = 0;
        start_raw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        start_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL glitch_pulse: got %0d pulses want 0", pulses);
        else n_pass++;
        n_checks++;
        if (dut.g_chan[4].cnt_q !== 3'd0) $display("FAIL glitch_counter: got %0d want 0", dut.g_chan[4].cnt_q);
        else n_pass++;
        start_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        start_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) $display("FAIL start_press: got %0d pulses want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int valids;
        cur_direction = 2'b10;
        valids        = 0;
        buttons_raw   = 4'b1010;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (direction_valid === 1'b1) valids++;
        end
        n_checks++;
        if (valids != 1) $display("FAIL simul_valid: got %0d pulses want 1", valids);
        else n_pass++;
        n_checks++;
        if (direction_req !== 2'b00) $display("FAIL simul_dir: got %b want 00", direction_req);
        else n_pass++;
        release_keys();
        valids      = 0;
        buttons_raw = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (direction_valid === 1'b1) valids++;
        end
        n_checks++;
        if (valids != 1 || direction_req !== 2'b10)
            $display("FAIL up_alone: got valid=%0d dir=%b want 1/10", valids, direction_req);
        else n_pass++;
        release_keys();
    endtask

    task automatic test_reverse();
        int valids;
        cur_direction = 2'b01;
        valids        = 0;
        buttons_raw   = 4'b1000;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (direction_valid === 1'b1) valids++;
        end
`ifdef SGA_REVERSE_BLOCK_EN
        n_checks++;
        if (valids != 0 || direction_req !== 2'b10)
            $display("FAIL reverse_blocked: got valid=%0d dir=%b want 0/10", valids, direction_req);
        else n_pass++;
`else
        n_checks++;
        if (valids != 1 || direction_req !== 2'b00)
            $display("FAIL reverse_accepted: got valid=%0d dir=%b want 1/00", valids, direction_req);
        else n_pass++;
`endif
        release_keys();
    endtask

    task automatic test_reset_mid_debounce();
        int bad;
        cur_direction = 2'b01;
        buttons_raw   = 4'b0100;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (dut.g_chan[2].cnt_q !== 3'd2) $display("FAIL mid_count: got %0d want 2", dut.g_chan[2].cnt_q);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (dut.g_chan[2].cnt_q !== 3'd0 || direction_req !== 2'b01 || buttons_clean !== 4'b0000)
            $display("FAIL mid_reset: got cnt=%0d dir=%b clean=%b want 0/01/0000",
                     dut.g_chan[2].cnt_q, direction_req, buttons_clean);
        else n_pass++;
        reset = 1'b0;
        bad   = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (buttons_clean[2] !== (k >= 2 + DEB)) bad++;
            if (buttons_pulse !== ((k == 2 + DEB) ? 4'b0100 : 4'b0000)) bad++;
            if (direction_valid !== (k == 3 + DEB)) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL mid_timeline: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (direction_req !== 2'b01) $display("FAIL mid_dir: got %b want 01", direction_req);
        else n_pass++;
        release_keys();
    endtask

    task automatic test_pause_level();
        pause_raw = 1'b1;
        for (int k = 0; k < 2 + DEB - 1; k++) tick();
        n_checks++;
        if (pause_level !== 1'b0) $display("FAIL pause_early: got %b want 0", pause_level);
        else n_pass++;
        tick();
        n_checks++;
        if (pause_level !== 1'b1) $display("FAIL pause_level: got %b want 1", pause_level);
        else n_pass++;
        pause_raw = 1'b0;
        for (int k = 0; k < 2 + DEB; k++) tick();
        n_checks++;
        if (pause_level !== 1'b0) $display("FAIL pause_release: got %b want 0", pause_level);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_reverse();
        test_reset_mid_debounce();
        test_pause_level();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
